fetch_unit: RTL and testbench

Front-end fetch stage that sits directly upstream of the instruction queue FIFO in the out-of-order core. It owns the architectural fetch PC and issues one 32-bit read per instruction to the instruction memory/cache port. It pushes {pc, instruction} entries into the queue under `full` backpressure. It also accepts a redirect from the commit/branch logic and discards any in-flight stale response.

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port, instruction-queue push port and redirect input.
// The master modport is the fetch unit; the slave modport is the memory/queue/commit side.
interface fetch_unit_if #(
  parameter int IQ_WIDTH = 64
);
  logic [31:0]         imem_addr;
  logic [3:0]          imem_rmask;
  logic [31:0]         imem_rdata;
  logic                imem_resp;
  logic                iq_enq;
  logic [IQ_WIDTH-1:0] iq_wdata;
  logic                iq_full;
  logic                redirect_valid;
  logic [31:0]         redirect_pc;

  modport master (
    output imem_addr, imem_rmask, iq_enq, iq_wdata,
    input  imem_rdata, imem_resp, iq_full, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, imem_rmask, iq_enq, iq_wdata,
    output imem_rdata, imem_resp, iq_full, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, keeps one instruction-memory read in flight and pushes {pc, inst}
// into the instruction queue; redirects replace the PC and squash any stale response.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int          IQ_WIDTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_hold;
  logic [31:0] w_hold_next;
  logic        w_enq;
  logic [31:0] w_enq_inst;
  logic [3:0]  w_rmask;
  logic [31:0] w_redirect_pc;

  assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};

  // State, PC and hold-buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_hold  <= 32'h0000_0000;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_hold  <= w_hold_next;
    end
  end

  // Next-state, PC update and handshake decode
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_hold_next  = r_hold;
    w_enq        = 1'b0;
    w_enq_inst   = 32'h0000_0000;
    w_rmask      = 4'h0;
    case (r_state)
      S_REQ: begin
        if (bus.redirect_valid) begin
          w_pc_next = w_redirect_pc;
        end else begin
          w_rmask      = 4'hf;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          // A response in the redirect cycle is already stale; otherwise it is still coming.
          w_pc_next    = w_redirect_pc;
          w_state_next = bus.imem_resp ? S_REQ : S_DISCARD;
        end else if (bus.imem_resp) begin
          if (!bus.iq_full) begin
            w_enq        = 1'b1;
            w_enq_inst   = bus.imem_rdata;
            w_pc_next    = r_pc + 32'd4;
            w_state_next = S_REQ;
          end else begin
            w_hold_next  = bus.imem_rdata;
            w_state_next = S_HOLD;
          end
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          w_pc_next    = w_redirect_pc;
          w_state_next = S_REQ;
        end else if (!bus.iq_full) begin
          w_enq        = 1'b1;
          w_enq_inst   = r_hold;
          w_pc_next    = r_pc + 32'd4;
          w_state_next = S_REQ;
        end else begin
          w_state_next = S_HOLD;
        end
      end
      S_DISCARD: begin
        if (bus.redirect_valid) begin
          w_pc_next = w_redirect_pc;
        end else begin
          w_pc_next = r_pc;
        end
        if (bus.imem_resp) begin
          w_state_next = S_REQ;
        end else begin
          w_state_next = S_DISCARD;
        end
      end
      default: begin
        w_state_next = S_REQ;
      end
    endcase
  end

  // Gating with rst keeps the strobes low while reset is held, even though the state reads REQ.
  assign bus.imem_addr  = r_pc;
  assign bus.imem_rmask = rst ? w_rmask : 4'h0;
  assign bus.iq_enq     = rst & w_enq;
  assign bus.iq_wdata   = (rst & w_enq) ? IQ_WIDTH'({r_pc, w_enq_inst}) : {IQ_WIDTH{1'b0}};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: a default-PC instance for the main scenarios and a
// second instance with RESET_PC at the top of the address space for the wrap case.
module tb_fetch_unit;

  logic clk;
  logic rst;
  logic rst_b;

  int total_cnt;
  int bad_cnt;
  int enq_cnt;
  int viol_resp;
  int viol_enq;
  logic outst;

  fetch_unit_if #(.IQ_WIDTH(64)) a ();
  fetch_unit_if #(.IQ_WIDTH(64)) b ();

  fetch_unit #(.RESET_PC(32'h1eceb000), .IQ_WIDTH(64)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  fetch_unit #(.RESET_PC(32'hfffffffc), .IQ_WIDTH(64)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Protocol monitor on instance A: responses only when a request is outstanding, no illegal enq.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      outst <= 1'b0;
    end else begin
      if (a.imem_resp && !outst) viol_resp <= viol_resp + 1;
      if (a.iq_enq && (a.iq_full || a.redirect_valid)) viol_enq <= viol_enq + 1;
      if (a.iq_enq) enq_cnt <= enq_cnt + 1;
      if (a.imem_rmask != 4'h0) outst <= 1'b1;
      else if (a.imem_resp) outst <= 1'b0;
    end
  end

  // Called settled in REQ: request, one-cycle response, enqueue; returns settled in REQ.
  task automatic fetch_ok(input logic [31:0] addr, input logic [31:0] inst);
    chk("req_rmask", {60'h0, a.imem_rmask}, 64'h0000_0000_0000_000f);
    chk("req_addr", {32'h0, a.imem_addr}, {32'h0, addr});
    cyc();
    a.imem_resp = 1'b1;
    a.imem_rdata = inst;
    #1;
    chk("wait_rmask", {60'h0, a.imem_rmask}, 64'h0);
    chk("wait_enq", {63'h0, a.iq_enq}, 64'h1);
    chk("wait_wdata", a.iq_wdata, {addr, inst});
    cyc();
    a.imem_resp = 1'b0;
    #1;
  endtask

  initial begin
    total_cnt = 0; bad_cnt = 0; enq_cnt = 0; viol_resp = 0; viol_enq = 0;
    rst = 1'b0; rst_b = 1'b0;
    a.imem_rdata = 32'h0; a.imem_resp = 1'b0; a.iq_full = 1'b0;
    a.redirect_valid = 1'b0; a.redirect_pc = 32'h0;
    b.imem_rdata = 32'h0; b.imem_resp = 1'b0; b.iq_full = 1'b0;
    b.redirect_valid = 1'b0; b.redirect_pc = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rmask", {60'h0, a.imem_rmask}, 64'h0);
    chk("rst_enq", {63'h0, a.iq_enq}, 64'h0);
    chk("rst_addr", {32'h0, a.imem_addr}, 64'h0000_0000_1ece_b000);
    chk("rst_wdata", a.iq_wdata, 64'h0);
    rst = 1'b1;
    #1;

    // Back-to-back fetches, response one cycle after each request
    fetch_ok(32'h1eceb000, 32'h00000013);
    fetch_ok(32'h1eceb004, 32'h00100093);
    fetch_ok(32'h1eceb008, 32'h00200113);

    // Response arrives while the queue is full for five cycles
    chk("full_req_addr", {32'h0, a.imem_addr}, 64'h0000_0000_1ece_b00c);
    cyc();
    a.imem_resp = 1'b1; a.imem_rdata = 32'h00a00093; a.iq_full = 1'b1;
    #1;
    chk("full_enq0", {63'h0, a.iq_enq}, 64'h0);
    cyc();
    a.imem_resp = 1'b0; a.imem_rdata = 32'hffffffff;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_enq", {63'h0, a.iq_enq}, 64'h0);
      chk("hold_rmask", {60'h0, a.imem_rmask}, 64'h0);
      cyc();
    end
    a.iq_full = 1'b0;
    #1;
    chk("hold_release_enq", {63'h0, a.iq_enq}, 64'h1);
    chk("hold_release_wdata", a.iq_wdata, 64'h1eceb00c_00a00093);
    cyc();
    #1;
    chk("after_hold_rmask", {60'h0, a.imem_rmask}, 64'h0000_0000_0000_000f);
    chk("after_hold_addr", {32'h0, a.imem_addr}, 64'h0000_0000_1ece_b010);

    // Redirect with a request in flight; stale response comes later and is dropped
    cyc();
    a.redirect_valid = 1'b1; a.redirect_pc = 32'h1eceb100;
    #1;
    chk("redir_wait_enq", {63'h0, a.iq_enq}, 64'h0);
    cyc();
    a.redirect_valid = 1'b0;
    #1;
    chk("discard_addr", {32'h0, a.imem_addr}, 64'h0000_0000_1ece_b100);
    chk("discard_rmask", {60'h0, a.imem_rmask}, 64'h0);
    cyc();
    a.imem_resp = 1'b1; a.imem_rdata = 32'hdeadbeef;
    #1;
    chk("discard_enq", {63'h0, a.iq_enq}, 64'h0);
    cyc();
    a.imem_resp = 1'b0;
    #1;

    // Redirect coincident with response in WAIT
    chk("post_discard_rmask", {60'h0, a.imem_rmask}, 64'h0000_0000_0000_000f);
    chk("post_discard_addr", {32'h0, a.imem_addr}, 64'h0000_0000_1ece_b100);
    cyc();
    a.imem_resp = 1'b1; a.imem_rdata = 32'h12345678;
    a.redirect_valid = 1'b1; a.redirect_pc = 32'h1eceb206;
    #1;
    chk("wait_redir_resp_enq", {63'h0, a.iq_enq}, 64'h0);
    cyc();
    a.imem_resp = 1'b0; a.redirect_valid = 1'b0;
    #1;
    chk("wait_redir_rmask", {60'h0, a.imem_rmask}, 64'h0000_0000_0000_000f);
    chk("wait_redir_addr", {32'h0, a.imem_addr}, 64'h0000_0000_1eceb204);

    // Redirect while holding a buffered instruction, queue just freed
    cyc();
    a.imem_resp = 1'b1; a.imem_rdata = 32'h87654321; a.iq_full = 1'b1;
    #1;
    cyc();
    a.imem_resp = 1'b0; a.iq_full = 1'b0;
    a.redirect_valid = 1'b1; a.redirect_pc = 32'h1eceb102;
    #1;
    chk("hold_redir_enq", {63'h0, a.iq_enq}, 64'h0);
    cyc();
    a.redirect_valid = 1'b0;
    #1;
    chk("hold_redir_rmask", {60'h0, a.imem_rmask}, 64'h0000_0000_0000_000f);
    chk("hold_redir_addr", {32'h0, a.imem_addr}, 64'h0000_0000_1ece_b100);

    // Redirect in REQ suppresses the request
    a.redirect_valid = 1'b1; a.redirect_pc = 32'h1eceb300;
    #1;
    chk("req_redir_rmask", {60'h0, a.imem_rmask}, 64'h0);
    cyc();
    a.redirect_valid = 1'b0;
    #1;
    chk("req_redir_addr", {32'h0, a.imem_addr}, 64'h0000_0000_1ece_b300);

    // Two redirects around DISCARD, the second coinciding with the stale response
    cyc();
    a.redirect_valid = 1'b1; a.redirect_pc = 32'h1eceb400;
    #1;
    cyc();
    a.redirect_pc = 32'h1eceb500; a.imem_resp = 1'b1; a.imem_rdata = 32'hcafef00d;
    #1;
    chk("discard_redir_enq", {63'h0, a.iq_enq}, 64'h0);
    cyc();
    a.redirect_valid = 1'b0; a.imem_resp = 1'b0;
    #1;
    chk("discard_redir_rmask", {60'h0, a.imem_rmask}, 64'h0000_0000_0000_000f);
    chk("discard_redir_addr", {32'h0, a.imem_addr}, 64'h0000_0000_1ece_b500);

    // Asynchronous reset in the middle of WAIT
    cyc();
    a.imem_resp = 1'b1; a.imem_rdata = 32'h0badf00d;
    #1;
    chk("pre_reset_enq", {63'h0, a.iq_enq}, 64'h1);
    rst = 1'b0;
    #1;
    chk("async_rst_enq", {63'h0, a.iq_enq}, 64'h0);
    chk("async_rst_rmask", {60'h0, a.imem_rmask}, 64'h0);
    chk("async_rst_addr", {32'h0, a.imem_addr}, 64'h0000_0000_1ece_b000);
    a.imem_resp = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    fetch_ok(32'h1eceb000, 32'h00300193);

    // Instance B: reset PC at the top of the address space wraps to zero
    rst_b = 1'b1;
    #1;
    chk("b_req_rmask", {60'h0, b.imem_rmask}, 64'h0000_0000_0000_000f);
    chk("b_req_addr", {32'h0, b.imem_addr}, 64'h0000_0000_ffff_fffc);
    cyc();
    b.imem_resp = 1'b1; b.imem_rdata = 32'h00000113;
    #1;
    chk("b_enq", {63'h0, b.iq_enq}, 64'h1);
    chk("b_wdata", b.iq_wdata, 64'hfffffffc_00000113);
    cyc();
    b.imem_resp = 1'b0;
    #1;
    chk("b_wrap_addr", {32'h0, b.imem_addr}, 64'h0);
    chk("b_wrap_rmask", {60'h0, b.imem_rmask}, 64'h0000_0000_0000_000f);

    cyc();
    chk("enq_count", {32'h0, enq_cnt}, 64'd5);
    chk("resp_protocol", {32'h0, viol_resp}, 64'd0);
    chk("enq_protocol", {32'h0, viol_enq}, 64'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
